// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: seven-segment controller for up to eight active-low HEX digits.
// It takes one write port with a valid/ready handshake and renders the value
// either as hex nibbles or as decimal, using a sequential double-dabble conversion.
// Each digit can be blanked or made to blink.
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, leading zeros of a
// decimal value are dark. Digit 0 always shows.
module hex_display_ctrl #(
    parameter int DIGITS     = 8,
    parameter int BLINK_HALF = 25000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [4*DIGITS-1:0]   wr_data,
    input  logic                  wr_mode,
    input  logic [DIGITS-1:0]     wr_blank,
    input  logic [DIGITS-1:0]     wr_blink,
    output logic                  busy,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   HEX
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = $clog2(BLINK_HALF);
    localparam int SW = $clog2(W) + 1;
    localparam logic [CW-1:0] CNT_MAX    = CW'(BLINK_HALF - 1);
    localparam logic [SW-1:0] SHIFT_LAST = SW'(W - 1);
    localparam logic [6:0]    SEG_DARK   = 7'h7F;
    localparam logic [6:0]    SEG_DASH   = 7'b0111111;

    // Largest value that fits in DIGITS decimal digits (10^DIGITS - 1).
    function automatic longint pow10_minus1(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p - 1;
    endfunction

    localparam logic [W-1:0] DEC_MAX = W'(pow10_minus1(DIGITS));

    // DE2-style active-low glyphs, bit 0 = segment a.
    function automatic logic [6:0] seg_decode(input logic [3:0] v);
        case (v)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    typedef enum logic {IDLE, CONV} state_t;

    state_t               state_reg;
    logic                 wr_ready_reg;
    logic                 busy_reg;
    logic                 overflow_reg;
    logic [W-1:0]         digit_reg;
    logic [DIGITS-1:0]    blank_reg;
    logic [DIGITS-1:0]    blink_reg;
    logic [W-1:0]         bin_reg;
    logic [W-1:0]         bcd_reg;
    logic [SW-1:0]        shift_cnt_reg;
    logic [CW-1:0]        blink_cnt_reg;
    logic                 phase_reg;
    logic [7*DIGITS-1:0]  hex_reg;
`ifdef LEADING_ZERO_BLANK_EN
    logic                 dec_reg;
`endif

    logic [W-1:0]         bcd_adj;
    logic [W-1:0]         bcd_next;
    logic [DIGITS-1:0]    lz_dark;
    logic [7*DIGITS-1:0]  hex_next;

    // Double-dabble step: add 3 to every nibble >= 5, then shift in the next MSB.
    // Because the value is range-checked first, the top BCD bit never carries out.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_dabble
        assign bcd_adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ?
                                    bcd_reg[4*gi +: 4] + 4'd3 : bcd_reg[4*gi +: 4];
    end
    assign bcd_next = W'({bcd_adj, bin_reg[W-1]});

`ifdef LEADING_ZERO_BLANK_EN
    // Digit i (i > 0) is a leading zero when it and every digit above it are zero.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_lz
        if (gi == 0) begin : g_lsd
            assign lz_dark[gi] = 1'b0;
        end else begin : g_upper
            assign lz_dark[gi] = dec_reg && (digit_reg[W-1:4*gi] == '0);
        end
    end
`else
    assign lz_dark = '0;
`endif

    // Per-digit segment select: blank > blink-dark > overflow dash > leading zero > glyph.
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_render
        assign hex_next[7*gi +: 7] =
            blank_reg[gi]                ? SEG_DARK :
            (blink_reg[gi] && phase_reg) ? SEG_DARK :
            overflow_reg                 ? SEG_DASH :
            lz_dark[gi]                  ? SEG_DARK :
                                           seg_decode(digit_reg[4*gi +: 4]);
    end

    // Write acceptance, range check and the bit-serial binary-to-BCD conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            wr_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            overflow_reg  <= 1'b0;
            digit_reg     <= '0;
            blank_reg     <= '1;
            blink_reg     <= '0;
            bin_reg       <= '0;
            bcd_reg       <= '0;
            shift_cnt_reg <= '0;
`ifdef LEADING_ZERO_BLANK_EN
            dec_reg       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (wr_valid) begin
                        blank_reg <= wr_blank;
                        blink_reg <= wr_blink;
`ifdef LEADING_ZERO_BLANK_EN
                        dec_reg   <= wr_mode;
`endif
                        if (!wr_mode) begin
                            digit_reg    <= wr_data;
                            overflow_reg <= 1'b0;
                        end else if (wr_data > DEC_MAX) begin
                            overflow_reg <= 1'b1;
                        end else begin
                            state_reg     <= CONV;
                            wr_ready_reg  <= 1'b0;
                            busy_reg      <= 1'b1;
                            bin_reg       <= wr_data;
                            bcd_reg       <= '0;
                            shift_cnt_reg <= '0;
                        end
                    end
                end
                CONV: begin
                    bin_reg       <= {bin_reg[W-2:0], 1'b0};
                    bcd_reg       <= bcd_next;
                    shift_cnt_reg <= shift_cnt_reg + 1'b1;
                    if (shift_cnt_reg == SHIFT_LAST) begin
                        digit_reg    <= bcd_next;
                        overflow_reg <= 1'b0;
                        state_reg    <= IDLE;
                        wr_ready_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Free-running blink timebase; writes never disturb it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blink_cnt_reg <= '0;
            phase_reg     <= 1'b0;
        end else if (blink_cnt_reg == CNT_MAX) begin
            blink_cnt_reg <= '0;
            phase_reg     <= ~phase_reg;
        end else begin
            blink_cnt_reg <= blink_cnt_reg + 1'b1;
        end
    end

    // Registered segment outputs, one cycle behind the digit/mask state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hex_reg <= '1;
        else       hex_reg <= hex_next;
    end

    assign wr_ready = wr_ready_reg;
    assign busy     = busy_reg;
    assign overflow = overflow_reg;
    assign HEX      = hex_reg;

endmodule

// File: tb/tb_hex_display_ctrl.sv
// tb_hex_display_ctrl: directed bench for hex_display_ctrl (DIGITS=8, BLINK_HALF=4).
// A behavioural model predicts HEX/wr_ready/busy/overflow every cycle. Literal
// expectations written by hand pin the key display patterns.
module tb_hex_display_ctrl;

    localparam int D  = 8;
    localparam int BH = 4;
`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZ_EN = 1'b1;
`else
    localparam bit LZ_EN = 1'b0;
`endif

    logic        clk      = 1'b0;
    logic        reset    = 1'b0;
    logic        wr_valid = 1'b0;
    logic        wr_mode  = 1'b0;
    logic [31:0] wr_data  = '0;
    logic [7:0]  wr_blank = '0;
    logic [7:0]  wr_blink = '0;
    logic        wr_ready;
    logic        busy;
    logic        overflow;
    logic [55:0] HEX;

    always #5 clk = ~clk;

    hex_display_ctrl #(.DIGITS(D), .BLINK_HALF(BH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_data  (wr_data),
        .wr_mode  (wr_mode),
        .wr_blank (wr_blank),
        .wr_blink (wr_blink),
        .busy     (busy),
        .overflow (overflow),
        .HEX      (HEX)
    );

    int checks = 0;
    int errors = 0;

    task automatic check56(input string name, input logic [55:0] act, input logic [55:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Lit segments of each glyph, by segment letter.
    string glyph_segs [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg",
                               "acdefg", "abc", "abcdefg", "abcdfg", "abcefg",
                               "cdefg", "adef", "bcdeg", "adefg", "aefg"};

    int          m_dig [8];
    int          m_conv_dig [8];
    logic [7:0]  m_blank;
    logic [7:0]  m_blink;
    bit          m_ovf, m_dec, m_ready, m_busy;
    int          m_n;
    int          m_conv_left;
    logic [55:0] m_hex;

    function automatic logic [6:0] glyph(input int v);
        string      s;
        logic [6:0] p;
        int         idx;
        s = glyph_segs[v];
        p = 7'h7F;
        for (int k = 0; k < s.len(); k++) begin
            idx = int'(s[k]) - 97;
            p[idx] = 1'b0;
        end
        return p;
    endfunction

    function automatic logic [55:0] render(input int phase);
        logic [55:0] h;
        logic [6:0]  g;
        bit          zeros_above;
        for (int i = 0; i < D; i++) begin
            zeros_above = 1'b1;
            for (int j = i; j < D; j++) if (m_dig[j] != 0) zeros_above = 1'b0;
            if (m_blank[i])                       g = 7'h7F;
            else if (m_blink[i] && phase == 1)    g = 7'h7F;
            else if (m_ovf)                       g = 7'b0111111;
            else if (LZ_EN && m_dec && i > 0 && zeros_above) g = 7'h7F;
            else                                  g = glyph(m_dig[i]);
            h[7*i +: 7] = g;
        end
        return h;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < D; i++) m_dig[i] = 0;
        m_blank = '1; m_blink = '0; m_ovf = 0; m_dec = 0;
        m_ready = 1; m_busy = 0; m_n = 0; m_conv_left = 0;
        m_hex = '1;
    endtask

    task automatic m_step();
        longint v;
        // HEX after this edge reflects the state and phase before it.
        m_hex = render((m_n / BH) % 2);
        m_n++;
        if (m_conv_left > 0) begin
            m_conv_left--;
            if (m_conv_left == 0) begin
                m_dig = m_conv_dig;
                m_ovf = 0; m_ready = 1; m_busy = 0;
            end
        end else if (wr_valid) begin
            m_blank = wr_blank; m_blink = wr_blink; m_dec = wr_mode;
            if (!wr_mode) begin
                for (int i = 0; i < D; i++) m_dig[i] = int'(wr_data[4*i +: 4]);
                m_ovf = 0;
            end else if (wr_data > 32'd99999999) begin
                m_ovf = 1;
            end else begin
                v = longint'(wr_data);
                for (int i = 0; i < D; i++) begin
                    m_conv_dig[i] = int'(v % 10);
                    v = v / 10;
                end
                m_conv_left = 4 * D;
                m_ready = 0; m_busy = 1;
            end
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge reset);
            if (reset) m_reset();
            else       m_step();
        end
    end

    // Cycle-by-cycle compare against the model, 2 time units after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            check56("cyc_hex", HEX, m_hex);
            check1("cyc_ready", wr_ready, m_ready);
            check1("cyc_busy", busy, m_busy);
            check1("cyc_overflow", overflow, m_ovf);
        end
    end

    // ---------------- stimulus ----------------
    task automatic do_write(input logic [31:0] d, input logic m,
                            input logic [7:0] bl, input logic [7:0] bk);
        @(negedge clk);
        wr_data = d; wr_mode = m; wr_blank = bl; wr_blink = bk; wr_valid = 1'b1;
        @(negedge clk);
        wr_valid = 1'b0;
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!wr_ready) begin
            errors++;
            $display("FAIL %s timeout waiting for wr_ready", name);
        end
    endtask

    initial begin
        int  n;
        bit  seen_dark, seen_lit;
        logic [55:0] exp0, exp42;

        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check56("reset_hex", HEX, {8{7'h7F}});
        check1("reset_ready", wr_ready, 1'b1);
        check1("reset_busy", busy, 1'b0);
        check1("reset_overflow", overflow, 1'b0);

        // Hex write: digits 7..0 = 0,1,2,3,A,b,C,d
        do_write(32'h0123ABCD, 1'b0, 8'h00, 8'h00);
        check1("hex_ready", wr_ready, 1'b1);
        @(negedge clk);
        check56("hex_0123ABCD", HEX, {7'h40, 7'h79, 7'h24, 7'h30, 7'h08, 7'h03, 7'h46, 7'h21});

        // Back-to-back hex writes on consecutive cycles
        @(negedge clk);
        wr_data = 32'h11111111; wr_mode = 1'b0; wr_blank = '0; wr_blink = '0; wr_valid = 1'b1;
        @(negedge clk);
        wr_data = 32'h89ABCDEF;
        @(negedge clk);
        wr_valid = 1'b0;
        check1("b2b_ready", wr_ready, 1'b1);
        @(negedge clk);
        check56("hex_89ABCDEF", HEX, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E});

        // Decimal write 12345678: 32 busy cycles, visible at E0+33
        do_write(32'd12345678, 1'b1, 8'h00, 8'h00);
        n = 0;
        while (busy && n < 100) begin
            n++;
            @(negedge clk);
        end
        check_int("dec_busy_cycles", n, 32);
        @(negedge clk);
        check56("dec_12345678", HEX, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00});

        // Handshake: hold wr_valid across the conversion of 99999999 with a hex write queued
        @(negedge clk);
        wr_data = 32'd99999999; wr_mode = 1'b1; wr_blank = '0; wr_blink = '0; wr_valid = 1'b1;
        @(negedge clk);
        wr_data = 32'hFEDCBA98; wr_mode = 1'b0;
        n = 0;
        while (!wr_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_int("hold_ready_wait", n, 32);
        @(negedge clk);
        wr_valid = 1'b0;
        check56("dec_99999999", HEX, {8{7'h10}});
        @(negedge clk);
        check56("hex_FEDCBA98", HEX, {7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00});

        // Overflow: 10^8 does not fit in eight digits
        do_write(32'd100000000, 1'b1, 8'h00, 8'h00);
        check1("ovf_flag", overflow, 1'b1);
        check1("ovf_no_busy", busy, 1'b0);
        @(negedge clk);
        check56("ovf_dashes", HEX, {8{7'b0111111}});
        do_write(32'h00000000, 1'b0, 8'h00, 8'h00);
        check1("ovf_cleared", overflow, 1'b0);

        // Decimal zero
        do_write(32'd0, 1'b1, 8'h00, 8'h00);
        wait_ready("dec_zero");
        @(negedge clk);
        exp0 = LZ_EN ? {{7{7'h7F}}, 7'h40} : {8{7'h40}};
        check56("dec_zero", HEX, exp0);

        // Blink digit 0, blank digit 7
        do_write(32'h87654321, 1'b0, 8'h80, 8'h01);
        seen_dark = 0; seen_lit = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check56("blank_d7", {49'b0, HEX[55:49]}, {49'b0, 7'h7F});
            if (HEX[6:0] == 7'h7F) seen_dark = 1;
            if (HEX[6:0] == 7'h79) seen_lit = 1;
        end
        check1("blink_dark_seen", seen_dark, 1'b1);
        check1("blink_lit_seen", seen_lit, 1'b1);

        // Reset at cycle 10 of a conversion
        do_write(32'd12345678, 1'b1, 8'h00, 8'h00);
        repeat (9) @(negedge clk);
        check1("pre_reset_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check56("mid_reset_hex", HEX, {8{7'h7F}});
        check1("mid_reset_busy", busy, 1'b0);
        check1("mid_reset_ready", wr_ready, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check56("post_reset_hex", HEX, {8{7'h7F}});

        // Small decimal value after the abort
        do_write(32'd42, 1'b1, 8'h00, 8'h00);
        wait_ready("dec_42");
        @(negedge clk);
        exp42 = LZ_EN ? {{6{7'h7F}}, 7'h19, 7'h24} : {{6{7'h40}}, 7'h19, 7'h24};
        check56("dec_42", HEX, exp42);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Parametrised seven-segment display controller driving up to eight active-low HEX digits from a single write port. It supersedes the fixed four-digit HEX PIO arrangement in the media computer. It adds:
- a valid/ready write handshake;
- hexadecimal or sequential binary-to-decimal (double-dabble) rendering;
- per-digit blanking and blinking.

It sits between a bus-side register interface and the board HEX pins.

## Interface
Parameters:
- DIGITS, 8: number of displayed digits, legal range 1..8.
- BLINK_HALF, 25000000: clock cycles per blink half-period, minimum 2.

Ports:
- clk  in  1  system clock. One clock; reset is asynchronous and active-high.
- reset  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_ready  out  1  controller can accept a write.
- wr_data  in  4*DIGITS  value to display; digit 0 = wr_data[3:0].
- wr_mode  in  1  0 = hex nibbles, 1 = unsigned binary rendered as decimal.
- wr_blank  in  DIGITS  1 = force digit dark.
- wr_blink  in  DIGITS  1 = digit blinks.
- busy  out  1  decimal conversion in progress.
- overflow  out  1  last decimal write exceeded 10^DIGITS-1.
- HEX  out  7*DIGITS  segments, active-low; digit i = HEX[7i+6:7i], bit 0 = a … bit 6 = g.

## Operation
- States:
  - IDLE: wr_ready=1.
  - CONV: wr_ready=0, busy=1.
- A write is accepted on a rising edge with wr_valid && wr_ready. wr_data, wr_mode, wr_blank and wr_blink are latched at that edge.
- Hex mode: the digit register is loaded directly from wr_data at the accept edge. The state stays IDLE, so back-to-back writes are allowed every cycle. overflow is cleared.
- Decimal mode, in-range value (wr_data ≤ 10^DIGITS-1):
  - Enter CONV.
  - Shift one bit per cycle, MSB first, applying add-3 to every BCD nibble ≥5 before each shift.
  - After exactly 4*DIGITS shift cycles, load the digit register and return to IDLE. overflow is cleared.
- Decimal mode, out-of-range value:
  - No conversion; stay IDLE.
  - Set overflow=1.
  - Every non-blanked digit shows "-" (segment g only, pattern 7'b0111111).
- Writes arriving during CONV are not accepted. The producer must hold wr_valid.
- Hex decode: 0-9 and A, b, C, d, E, F in standard DE2 glyphs. Blank = 7'h7F.
- Blink:
  - A free-running counter counts 0..BLINK_HALF-1; phase toggles on wrap.
  - When phase=1, digits with blink=1 are dark.
  - The counter and phase are not reset by writes.
- Per-digit precedence: blank > blink-dark > overflow dash > glyph.

## Timing
- Reset values: HEX all 1s (all dark), wr_ready=1, busy=0, overflow=0. Digit register = 0, blank mask all 1s, blink mask 0, phase 0, blink counter 0, state IDLE.
- Reset asserted mid-CONV aborts the conversion immediately. The display reverts to reset values with no partial update.
- HEX is registered, with latency measured from the accept edge E0:
  - hex-mode and overflow writes are visible at E0+1;
  - decimal writes load digits at E0+4*DIGITS and are visible at E0+4*DIGITS+1.
- wr_ready rises at the edge that loads the converted digits. A new write may be accepted on that same edge +1 cycle, i.e. the next cycle.
- A blink phase change appears on HEX one cycle after the counter wraps.

## Configuration
- Macro LEADING_ZERO_BLANK_EN:
  - Defined: in decimal mode, zero digits above the most significant non-zero digit are dark. Digit 0 always shows, so a value of 0 displays "0". Hex mode is unaffected.
  - Undefined: all DIGITS digits show, including leading zeros.

## Test plan
- Reset check: assert reset, then release → HEX all 7'h7F and wr_ready=1.
- Hex write: DIGITS=8, hex mode, wr_data=32'h0123ABCD, blank=0, blink=0 → at E0+1, digits 0..7 show D,C,B,A,3,2,1,0. wr_ready stays 1 throughout.
- Decimal write: DIGITS=8, decimal mode, wr_data=12345678 → busy high for 32 cycles; at E0+33 HEX shows 1,2,3,4,5,6,7,8 (digit 7 down to 0).
  - With LEADING_ZERO_BLANK_EN, wr_data=42 → digits 2..7 are dark.
- Overflow: DIGITS=4, decimal mode, wr_data=16'd10000 → overflow=1, all four digits show 7'b0111111, no busy pulse. A following hex write clears overflow.
- Blink and blank: BLINK_HALF=4, blink=8'h01, blank=8'h80 → digit 0 toggles dark/lit every 4 cycles; digit 7 stays dark in both phases.
- Handshake and reset: hold wr_valid during CONV → no second accept until wr_ready returns. Assert reset at cycle 10 of a conversion → HEX all dark and busy=0 immediately.
